// File: rtl/plg_pkg.sv
// Shared definitions for the pulse-to-level generator.
// Contents:
//   plg_state_t : window FSM state (IDLE, HIGH, GAP)
//   max_int     : elaboration-time helper used to size the window counter
package plg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } plg_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter used to hold the number of queued requests.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   inc, dec   : increment / decrement requests for this cycle
//   count      : registered count
//   sat        : count is at its maximum (2^W-1)
//   drop       : an increment was refused because the count is saturated
//   cancel     : inc and dec arrived together and cancelled out
module sat_updown_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat,
  output logic         drop,
  output logic         cancel
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count  = count_q;
  assign sat    = (count_q == MAX_COUNT);
  // A simultaneous dec frees a slot, so inc&dec never drops even when full.
  assign cancel = inc & dec;
  assign drop   = inc & ~dec & sat;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && !sat) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pulse_level_gen.sv
// Converts single-cycle request pulses into level windows: each accepted
// request gives HIGH_CYCLES of level_out=1 followed by at least LOW_CYCLES
// of level_out=0. Requests arriving while a window or gap is running are
// queued in a saturating counter and replayed back-to-back.
// Handshake: there is no back-pressure. A request is accepted whenever
// pulse_in & en is high at a rising clk edge; it is either started at once
// (IDLE), queued (HIGH/GAP), or dropped with overflow set (queue full).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   pulse_in   : single-cycle request
//   en         : accept enable (does not affect queued/in-flight work)
//   clr_ovf    : clears the sticky overflow flag (a new overflow wins)
//   level_out  : generated level, registered
//   busy       : FSM is not IDLE
//   pending    : queued requests not yet served
//   overflow   : sticky, a request was dropped because pending was full
module pulse_level_gen
  import plg_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              en,
  input  logic              clr_ovf,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CW = $clog2(max_int(HIGH_CYCLES, LOW_CYCLES) + 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(LOW_CYCLES - 1);

  // Debug view of the window machinery for bound checkers.
  typedef struct packed {
    plg_state_t    state;
    logic [CW-1:0] cnt;
    logic          pend_sat;
    logic          pend_cancel;
  } plg_dbg_t;

  plg_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          ovf_q, ovf_d;

  logic accept;
  logic last_gap;
  logic has_pend;
  logic pend_inc, pend_dec;
  logic pend_sat, pend_drop, pend_cancel;
  plg_dbg_t dbg;

  assign accept   = pulse_in & en;
  assign last_gap = (state_q == GAP) && (cnt_q == '0);
  assign has_pend = (pending != '0);

  // On the last gap cycle with an empty queue a new request starts the next
  // window directly instead of passing through the queue.
  assign pend_inc = accept && (state_q != IDLE) && !(last_gap && !has_pend);
  assign pend_dec = last_gap && has_pend;

  sat_updown_cnt #(
    .W (PEND_W)
  ) u_pend_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (pend_inc),
    .dec    (pend_dec),
    .count  (pending),
    .sat    (pend_sat),
    .drop   (pend_drop),
    .cancel (pend_cancel)
  );

  assign dbg = '{state: state_q, cnt: cnt_q, pend_sat: pend_sat, pend_cancel: pend_cancel};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
          level_d = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (has_pend || accept) begin
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
            level_d = 1'b1;
          end else begin
            state_d = IDLE;
            level_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase

    // Set has priority over clear.
    if (pend_drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign level_out = level_q;
  assign busy      = (state_q != IDLE);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_level_gen.sv
// Directed bench for pulse_level_gen. Two instances: u_dut (PEND_W=3) for
// window timing, queuing, reset and enable; u_dut2 (PEND_W=2) for queue
// saturation and the overflow flag. Step index i in run_seq means the value
// sampled 1ns after the i-th clock edge of the sequence, where edge 0 is the
// edge that samples pmask[0].
module tb_pulse_level_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       p1, en1, clr1;
  logic       p2, en2, clr2;
  logic       lv1, busy1, ovf1;
  logic [2:0] pend1;
  logic       lv2, busy2, ovf2;
  logic [1:0] pend2;

  int vectors     = 0;
  int miscompares = 0;
  int rises1      = 0;
  int rises2      = 0;
  logic prev1     = 1'b0;
  logic prev2     = 1'b0;

  logic [31:0] pend_log[32];
  logic [31:0] ovf_log[32];

  pulse_level_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_W(3)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (p1),
    .en        (en1),
    .clr_ovf   (clr1),
    .level_out (lv1),
    .busy      (busy1),
    .pending   (pend1),
    .overflow  (ovf1)
  );

  pulse_level_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_W(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (p2),
    .en        (en2),
    .clr_ovf   (clr2),
    .level_out (lv2),
    .busy      (busy2),
    .pending   (pend2),
    .overflow  (ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns later, count rising edges of both levels.
  task automatic tick();
    @(posedge clk);
    #1;
    if (lv1 === 1'b1 && prev1 !== 1'b1) rises1++;
    if (lv2 === 1'b1 && prev2 !== 1'b1) rises2++;
    prev1 = lv1;
    prev2 = lv2;
  endtask

  task automatic run_seq(input int sel, input string tag, input logic [31:0] pmask,
                         input logic [31:0] cmask, input logic [31:0] lmask,
                         input logic [31:0] bmask, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 1) begin
        p1   = pmask[i];
        clr1 = cmask[i];
      end else begin
        p2   = pmask[i];
        clr2 = cmask[i];
      end
      tick();
      p1 = 1'b0; clr1 = 1'b0;
      p2 = 1'b0; clr2 = 1'b0;
      if (sel == 1) begin
        chk($sformatf("%s level[%0d]", tag, i), 32'(lv1), 32'(lmask[i]));
        chk($sformatf("%s busy[%0d]", tag, i), 32'(busy1), 32'(bmask[i]));
        pend_log[i] = 32'(pend1);
        ovf_log[i]  = 32'(ovf1);
      end else begin
        chk($sformatf("%s level[%0d]", tag, i), 32'(lv2), 32'(lmask[i]));
        chk($sformatf("%s busy[%0d]", tag, i), 32'(busy2), 32'(bmask[i]));
        pend_log[i] = 32'(pend2);
        ovf_log[i]  = 32'(ovf2);
      end
    end
  endtask

  initial begin
    // Clock/reset
    rst_n = 1'b0;
    p1 = 1'b0; en1 = 1'b1; clr1 = 1'b0;
    p2 = 1'b0; en2 = 1'b1; clr2 = 1'b0;
    repeat (3) tick();
    chk("reset level", 32'(lv1), 0);
    chk("reset busy", 32'(busy1), 0);
    chk("reset pending", 32'(pend1), 0);
    chk("reset overflow", 32'(ovf1), 0);
    chk("reset2 level", 32'(lv2), 0);
    chk("reset2 pending", 32'(pend2), 0);
    chk("reset2 overflow", 32'(ovf2), 0);
    rst_n = 1'b1;
    tick();

    // Single pulse: high 0-3, gap 4-5, idle from 6.
    rises1 = 0;
    run_seq(1, "single", 32'h1, 32'h0, 32'h0000_000F, 32'h0000_003F, 10);
    chk("single pending", pend_log[5], 0);
    chk("single rises", 32'(rises1), 1);

    // Pulses at 0,2,3: windows 0-3, 6-9, 12-15, idle from 18.
    rises1 = 0;
    run_seq(1, "burst", 32'hD, 32'h0, 32'h0000_F3CF, 32'h0003_FFFF, 22);
    chk("burst pend[2]", pend_log[2], 1);
    chk("burst pend[3]", pend_log[3], 2);
    chk("burst pend[5]", pend_log[5], 2);
    chk("burst pend[6]", pend_log[6], 1);
    chk("burst pend[11]", pend_log[11], 1);
    chk("burst pend[12]", pend_log[12], 0);
    chk("burst rises", 32'(rises1), 3);

    // Pulses at 0,2,6: edge 6 is the last gap cycle with pending=1 -> cancel.
    rises1 = 0;
    run_seq(1, "lastgap", 32'h45, 32'h0, 32'h0000_F3CF, 32'h0003_FFFF, 22);
    chk("lastgap pend[2]", pend_log[2], 1);
    chk("lastgap pend[6]", pend_log[6], 1);
    chk("lastgap pend[11]", pend_log[11], 1);
    chk("lastgap pend[12]", pend_log[12], 0);
    chk("lastgap rises", 32'(rises1), 3);

    // Pulses at 0,6: last gap cycle with empty queue starts a window directly.
    rises1 = 0;
    run_seq(1, "b2b", 32'h41, 32'h0, 32'h0000_03CF, 32'h0000_0FFF, 16);
    chk("b2b pend[6]", pend_log[6], 0);
    chk("b2b rises", 32'(rises1), 2);

    // Reset mid-window with one request queued and pulse_in high.
    p1 = 1'b1; tick();
    p1 = 1'b1; tick();
    chk("prerst level", 32'(lv1), 1);
    chk("prerst pending", 32'(pend1), 1);
    rst_n = 1'b0; p1 = 1'b1;
    tick();
    rst_n = 1'b1; p1 = 1'b0;
    chk("rst level", 32'(lv1), 0);
    chk("rst busy", 32'(busy1), 0);
    chk("rst pending", 32'(pend1), 0);
    rises1 = 0;
    run_seq(1, "postrst", 32'h0, 32'h0, 32'h0, 32'h0, 10);
    chk("postrst rises", 32'(rises1), 0);

    // en=0 ignores the pulse.
    en1 = 1'b0;
    run_seq(1, "en0", 32'h1, 32'h0, 32'h0, 32'h0, 8);
    chk("en0 pending", pend_log[0], 0);
    en1 = 1'b1;
    chk("dut1 overflow", 32'(ovf1), 0);

    // PEND_W=2: pulses 0-4, queue fills to 3 at edge 3, edge-4 pulse dropped.
    rises2 = 0;
    run_seq(2, "ovf", 32'h1F, 32'h0, 32'h003C_F3CF, 32'h00FF_FFFF, 28);
    chk("ovf pend[3]", pend_log[3], 3);
    chk("ovf pend[4]", pend_log[4], 3);
    chk("ovf flag[3]", ovf_log[3], 0);
    chk("ovf flag[4]", ovf_log[4], 1);
    chk("ovf flag[27]", ovf_log[27], 1);
    chk("ovf rises", 32'(rises2), 4);

    // Overflow recurs in the same cycle as clr_ovf: set wins.
    run_seq(2, "ovf2", 32'h1F, 32'h10, 32'h003C_F3CF, 32'h00FF_FFFF, 28);
    chk("ovf2 flag[4]", ovf_log[4], 1);
    chk("ovf2 pend[4]", pend_log[4], 3);

    // clr_ovf alone clears the flag.
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    chk("clr flag", 32'(ovf2), 0);
    tick();
    chk("clr flag hold", 32'(ovf2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
